// File: rtl/fma16_op_sched.sv
// Two-port round-robin sequencer for the combinational fma16 datapath, treated as a DP_LAT-cycle multicycle path.
// Optional sticky flag accumulator enabled by defining FMA16_SCHED_STICKY_FLAGS_EN.
module fma16_op_sched #(
  parameter int DP_LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_x,
  input  logic [31:0] req_y,
  input  logic [31:0] req_z,
  input  logic [11:0] req_ctl,
  input  logic        flush,
  output logic [15:0] dp_x,
  output logic [15:0] dp_y,
  output logic [15:0] dp_z,
  output logic [5:0]  dp_ctl,
  input  logic [15:0] dp_result,
  input  logic [3:0]  dp_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic        rsp_id,
  output logic        busy
`ifdef FMA16_SCHED_STICKY_FLAGS_EN
  ,
  input  logic        flags_clr,
  output logic [3:0]  sticky_flags
`endif
);

  localparam int DATA_W = 16;
  localparam int CTL_W  = 6;

  generate
    if (DP_LAT < 1 || DP_LAT > 15) begin : g_lat_check
      $error("fma16_op_sched: DP_LAT must lie in 1..15");
    end
  endgenerate

  localparam logic [3:0] LP_CNT_INIT = 4'(DP_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_last_grant;
  logic [DATA_W-1:0]   r_x;
  logic [DATA_W-1:0]   r_y;
  logic [DATA_W-1:0]   r_z;
  logic [CTL_W-1:0]    r_ctl;
  logic [DATA_W-1:0]   r_rsp_result;
  logic [3:0]          r_rsp_flags;
  logic                r_rsp_id;
  logic                r_rsp_valid;
  logic                r_busy;

  logic                w_grant;
  logic                w_accept;
  logic                w_capture;
  logic [DATA_W-1:0]   w_sel_x;
  logic [DATA_W-1:0]   w_sel_y;
  logic [DATA_W-1:0]   w_sel_z;
  logic [CTL_W-1:0]    w_sel_ctl;

  // On a tie the requester that did not win last time is served.
  assign w_grant   = (req_valid == 2'b11) ? ~r_last_grant : req_valid[1];
  assign w_accept  = (r_state == S_IDLE) && (|req_valid) && !flush;
  assign w_capture = (r_state == S_WAIT) && !flush && (r_cnt == 4'd0);

  assign w_sel_x   = w_grant ? req_x[31:16]  : req_x[15:0];
  assign w_sel_y   = w_grant ? req_y[31:16]  : req_y[15:0];
  assign w_sel_z   = w_grant ? req_z[31:16]  : req_z[15:0];
  assign w_sel_ctl = w_grant ? req_ctl[11:6] : req_ctl[5:0];

  always_comb begin
    req_ready = 2'b00;
    if (w_accept) req_ready[w_grant] = 1'b1;
  end

  assign dp_x       = r_x;
  assign dp_y       = r_y;
  assign dp_z       = r_z;
  assign dp_ctl     = r_ctl;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_flags  = r_rsp_flags;
  assign rsp_id     = r_rsp_id;
  assign busy       = r_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_last_grant <= 1'b1;
      r_x          <= '0;
      r_y          <= '0;
      r_z          <= '0;
      r_ctl        <= '0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
      r_rsp_id     <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_x          <= w_sel_x;
            r_y          <= w_sel_y;
            r_z          <= w_sel_z;
            r_ctl        <= w_sel_ctl;
            r_last_grant <= w_grant;
            r_cnt        <= LP_CNT_INIT;
            r_state      <= S_WAIT;
            r_busy       <= 1'b1;
          end
        end
        S_WAIT: begin
          if (flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt == 4'd0) begin
            // Operands have been stable for DP_LAT cycles: sample the datapath.
            r_rsp_result <= dp_result;
            r_rsp_flags  <= dp_flags;
            r_rsp_id     <= r_last_grant;
            r_rsp_valid  <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          if (flush || rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef FMA16_SCHED_STICKY_FLAGS_EN
  logic [3:0] r_sticky;

  // A clear coinciding with a capture leaves only the new flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sticky <= 4'b0000;
    end else if (w_capture) begin
      r_sticky <= (flags_clr ? 4'b0000 : r_sticky) | dp_flags;
    end else if (flags_clr) begin
      r_sticky <= 4'b0000;
    end
  end

  assign sticky_flags = r_sticky;
`endif

endmodule

// File: tb/tb_fma16_op_sched.sv
// Self-checking bench for fma16_op_sched with a behavioural datapath stand-in and arbitration model.
module tb_fma16_op_sched;

  localparam int DP_LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] px [2];
  logic [15:0] py [2];
  logic [15:0] pz [2];
  logic [5:0]  pc [2];
  logic [31:0] req_x, req_y, req_z;
  logic [11:0] req_ctl;
  logic        flush;
  logic [15:0] dp_x, dp_y, dp_z;
  logic [5:0]  dp_ctl;
  logic [15:0] dp_result;
  logic [3:0]  dp_flags;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        rsp_id;
  logic        busy;
`ifdef FMA16_SCHED_STICKY_FLAGS_EN
  logic        flags_clr;
  logic [3:0]  sticky_flags;
  logic [3:0]  m_sticky;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic m_last;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign req_x   = {px[1], px[0]};
  assign req_y   = {py[1], py[0]};
  assign req_z   = {pz[1], pz[0]};
  assign req_ctl = {pc[1], pc[0]};

  function automatic logic [15:0] model_res(logic [15:0] x, logic [15:0] y, logic [15:0] z, logic [5:0] c);
    if (x == 16'h3C00 && y == 16'h4000 && z == 16'h3C00 && c == 6'b110000) return 16'h4200;
    return (x ^ {y[7:0], y[15:8]}) + z + {10'd0, c};
  endfunction

  function automatic logic [3:0] model_flg(logic [15:0] x, logic [15:0] y);
    return x[3:0] ^ y[3:0];
  endfunction

  assign dp_result = model_res(dp_x, dp_y, dp_z, dp_ctl);
  assign dp_flags  = model_flg(dp_x, dp_y);

  fma16_op_sched #(.DP_LAT(DP_LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_ctl(req_ctl),
    .flush(flush),
    .dp_x(dp_x), .dp_y(dp_y), .dp_z(dp_z), .dp_ctl(dp_ctl),
    .dp_result(dp_result), .dp_flags(dp_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_id(rsp_id),
    .busy(busy)
`ifdef FMA16_SCHED_STICKY_FLAGS_EN
    , .flags_clr(flags_clr), .sticky_flags(sticky_flags)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_payload(input int r);
    px[r] = 16'($urandom);
    py[r] = 16'($urandom);
    pz[r] = 16'($urandom);
    pc[r] = 6'($urandom);
  endtask

  // One complete transaction from an IDLE cycle through the response handshake.
  task automatic op(input int bp, input bit rnd, input bit clr_cap, output int acc, output int g);
    logic [15:0] ex, ey, ez, er;
    logic [5:0]  ec;
    logic [3:0]  ef;
    rsp_ready = (bp == 0);
    #1;
    g = (req_valid == 2'b11) ? (m_last ? 0 : 1) : (req_valid[1] ? 1 : 0);
    chk("req_ready_grant", req_ready, (g == 1) ? 2'b10 : 2'b01);
    chk("busy_idle", busy, 0);
    ex = px[g]; ey = py[g]; ez = pz[g]; ec = pc[g];
    er = model_res(ex, ey, ez, ec);
    ef = model_flg(ex, ey);
    acc = cyc;
    step();
    m_last = 1'(g);
    for (int i = 1; i <= DP_LAT; i++) begin
      if (i == 1 && rnd) begin
        req_valid[g] = 1'($urandom);
        rand_payload(g);
      end
      #1;
      chk("busy_wait", busy, 1);
      chk("ready_wait", req_ready, 2'b00);
      chk("rsp_valid_wait", rsp_valid, 0);
      chk("dp_x", dp_x, ex);
      chk("dp_y", dp_y, ey);
      chk("dp_z", dp_z, ez);
      chk("dp_ctl", dp_ctl, ec);
`ifdef FMA16_SCHED_STICKY_FLAGS_EN
      if (clr_cap && i == DP_LAT) flags_clr = 1'b1;
`endif
      step();
    end
`ifdef FMA16_SCHED_STICKY_FLAGS_EN
    flags_clr = 1'b0;
    m_sticky = (clr_cap ? 4'b0000 : m_sticky) | ef;
    chk("sticky", sticky_flags, m_sticky);
`else
    if (clr_cap) $display("note: sticky feature not built");
`endif
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_result", rsp_result, er);
    chk("rsp_flags", rsp_flags, ef);
    chk("rsp_id", rsp_id, g);
    if (bp > 0) begin
      repeat (bp) begin
        step();
        chk("bp_valid", rsp_valid, 1);
        chk("bp_result", rsp_result, er);
        chk("bp_id", rsp_id, g);
        chk("bp_ready", req_ready, 2'b00);
      end
      rsp_ready = 1'b1;
    end
    step();
    chk("rsp_valid_after", rsp_valid, 0);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, prev, g;
    reset = 1'b1; req_valid = 2'b00; flush = 1'b0; rsp_ready = 1'b0;
    for (int r = 0; r < 2; r++) begin px[r] = 0; py[r] = 0; pz[r] = 0; pc[r] = 0; end
    m_last = 1'b1;
`ifdef FMA16_SCHED_STICKY_FLAGS_EN
    flags_clr = 1'b0; m_sticky = 4'b0000;
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_dp_x", dp_x, 0);
    chk("rst_dp_ctl", dp_ctl, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_flags", rsp_flags, 0);
    chk("rst_rsp_id", rsp_id, 0);
`ifdef FMA16_SCHED_STICKY_FLAGS_EN
    chk("rst_sticky", sticky_flags, 0);
`endif

    // Both requesters held valid: strict alternation starting at 0.
    rand_payload(0); rand_payload(1);
    req_valid = 2'b11;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      op(0, 0, 0, acc, g);
      chk("grant_seq", g, i % 2);
      if (i > 0) chk("accept_spacing", acc - prev, DP_LAT + 2);
      prev = acc;
    end

    // Directed single operation.
    px[0] = 16'h3C00; py[0] = 16'h4000; pz[0] = 16'h3C00; pc[0] = 6'b110000;
    req_valid = 2'b01;
    op(0, 0, 0, acc, g);
    chk("single_result", rsp_result, 16'h4200);

    // Long backpressure.
    rand_payload(1);
    req_valid = 2'b10;
    op(10, 0, 0, acc, g);

    // Flush while idle blocks the accept.
    req_valid = 2'b01; flush = 1'b1;
    #1 chk("flush_idle_ready", req_ready, 2'b00);
    step();
    chk("flush_idle_busy", busy, 0);
    flush = 1'b0;

    // Flush in the second WAIT cycle, req1 pending.
    #1 chk("pre_flush_ready", req_ready, 2'b01);
    step();
    m_last = 1'b0;
    req_valid = 2'b10;
    step();
    flush = 1'b1;
    #1 chk("flush_wait_ready", req_ready, 2'b00);
    step();
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_rsp_valid", rsp_valid, 0);
    op(0, 0, 0, acc, g);
    chk("flush_next_grant", g, 1);

    // Asynchronous reset while in DONE.
    req_valid = 2'b01; rsp_ready = 1'b0;
    #1 chk("pre_rst_ready", req_ready, 2'b01);
    step();
    repeat (DP_LAT) step();
    chk("pre_rst_done", rsp_valid, 1);
    reset = 1'b1;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_dp_x", dp_x, 0);
    chk("midrst_rsp_result", rsp_result, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    m_last = 1'b1;
`ifdef FMA16_SCHED_STICKY_FLAGS_EN
    m_sticky = 4'b0000;
`endif
    req_valid = 2'b11;
    op(0, 0, 0, acc, g);
    chk("post_rst_grant", g, 0);

`ifdef FMA16_SCHED_STICKY_FLAGS_EN
    // Sticky accumulation and clear-at-capture.
    req_valid = 2'b01; py[0] = 16'h0000;
    px[0] = 16'h1231; op(0, 0, 0, acc, g);
    px[0] = 16'h5674; op(0, 0, 0, acc, g);
    chk("sticky_0101", sticky_flags, 4'b0101);
    px[0] = 16'h9AB8; op(0, 0, 1, acc, g);
    chk("sticky_clr_cap", sticky_flags, 4'b1000);
`endif

    // Randomized traffic with random backpressure.
    rand_payload(0); rand_payload(1);
    for (int i = 0; i < 24; i++) begin
      if (req_valid == 2'b00) req_valid[$urandom % 2] = 1'b1;
      op(int'($urandom % 3), 1, 0, acc, g);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fma16_op_sched.md
Name: fma16_op_sched

Overview:
- Sequencing controller and two-port arbiter in front of the combinational fma16 datapath (multiply, align, add, mshift normalize, round).
- Treats the datapath as a DP_LAT-cycle multicycle path. Holds operands stable, waits DP_LAT cycles, then captures the result and flags.
- Shares the single datapath between two requesters using round-robin arbitration. Returns each result tagged with the requester id over a valid/ready response channel.

Parameters:
- DP_LAT, 3, cycles the datapath needs from operand-stable to result-valid; legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  2  per-requester request valid; bit i = requester i
- req_ready  out  2  per-requester accept; at most one bit high per cycle
- req_x  in  32  requester operand x; [15:0] = req0, [31:16] = req1
- req_y  in  32  requester operand y; same packing as req_x
- req_z  in  32  requester operand z; same packing as req_x
- req_ctl  in  12  per requester 6 bits {mul, add, negp, negz, roundmode[1:0]}; [5:0] = req0, [11:6] = req1
- flush  in  1  synchronous abort of the in-flight operation
- dp_x, dp_y, dp_z  out  16 each  operands driven to the datapath
- dp_ctl  out  6  control fields driven to the datapath
- dp_result  in  16  datapath result
- dp_flags  in  4  datapath flags {nv, of, uf, nx}
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_result  out  16  captured result
- rsp_flags  out  4  captured flags
- rsp_id  out  1  requester id of the response
- busy  out  1  high whenever state != IDLE

Behaviour:
- States are IDLE, WAIT and DONE.
- Reset values:
  - state = IDLE, cnt = 0, last_grant = 1 (so requester 0 wins the first tie).
  - Operand and control registers = 0, so dp_x/dp_y/dp_z/dp_ctl = 0.
  - rsp_result = 0, rsp_flags = 0, rsp_id = 0, rsp_valid = 0, req_ready = 0, busy = 0.
- IDLE:
  - grant = the requester with valid asserted. If both are valid, grant = ~last_grant.
  - req_ready[grant] is high combinationally in the same cycle (depends only on state and req_valid).
  - On the accept edge: capture that requester's x/y/z/ctl into the operand registers, set last_grant = grant, load cnt = DP_LAT-1, go to WAIT.
  - With no request pending, stay in IDLE.
- WAIT:
  - dp_* are driven only from the operand registers and are stable for the whole state.
  - cnt decrements by 1 each cycle.
  - On the edge where cnt == 0: capture dp_result/dp_flags into the rsp_result/rsp_flags registers, set rsp_id = last_grant, go to DONE.
  - This gives exactly DP_LAT WAIT cycles.
- DONE:
  - rsp_valid = 1. rsp_result/rsp_flags/rsp_id are held stable until the handshake.
  - On rsp_valid & rsp_ready go to IDLE. No new request is accepted in the same cycle.
- Minimum accept-to-accept spacing is DP_LAT + 2 cycles. Minimum accept-to-rsp_valid latency is DP_LAT + 1 cycles.
- req_ready is 0 in WAIT and DONE. A requester must hold valid and payload until accepted.
- Flush:
  - In WAIT or DONE: go to IDLE on the next edge. The response is dropped (rsp_valid low next cycle) and last_grant is kept.
  - In IDLE: no effect. Flush has priority over an accept in the same cycle, so req_ready = 0 while flush is high.
- Reset asserted mid-operation: immediately returns all state to the reset values. The in-flight operation is lost, with no response.
- cnt is 4 bits wide. A DP_LAT outside 1..15 is a compile-time error (generate-time check).

Optional Feature:
- Macro: FMA16_SCHED_STICKY_FLAGS_EN.
- When defined, the block adds:
  - output sticky_flags[3:0], reset to 0, which ORs in dp_flags at every WAIT-exit capture;
  - input flags_clr, which zeroes sticky_flags on the next edge.
- If flags_clr coincides with a capture, the register takes the captured flags only (the clear acts first, then the new flags are ORed in).
- A flushed operation does not update sticky_flags.
- When undefined: neither port exists and no sticky register is built.

Test Plan:
- Single op, DP_LAT = 3:
  - Stimulus: req_valid = 01, x = 0x3C00 (1.0), y = 0x4000 (2.0), z = 0x3C00, ctl = {1,1,0,0,00}, with the model datapath returning 0x4200 and flags = 0000.
  - Required: req_ready = 01 at cycle 0; dp_* stable for cycles 1-3; rsp_valid at cycle 4 with result 0x4200, id 0.
- Simultaneous requests:
  - Stimulus: req_valid = 11 held continuously, with the first request made after reset.
  - Required: grants are 0, 1, 0, 1 in order; rsp_id follows the same sequence; spacing is 5 cycles between accepts with rsp_ready tied to 1.
- Backpressure:
  - Stimulus: rsp_ready = 0 for 10 cycles in DONE.
  - Required: rsp_valid, rsp_result and rsp_id are held unchanged; req_ready = 00 throughout; rsp_ready = 1 causes a return to IDLE the next cycle.
- Flush:
  - Stimulus: flush in the second WAIT cycle.
  - Required: IDLE on the next edge; rsp_valid never asserts; the pending req1 is granted the following cycle.
- Reset mid-operation:
  - Stimulus: reset pulsed while in DONE.
  - Required: rsp_valid = 0 and busy = 0 asynchronously; after release, with both requesting, requester 0 is granted first.
- FMA16_SCHED_STICKY_FLAGS_EN defined:
  - Stimulus: two ops returning flags 0001 then 0100.
  - Required: sticky_flags = 0101; flags_clr coincident with a third capture of 1000 yields 1000.
